// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, issues one I-cache block
// request at a time and arbitrates flush/mispredict/jump redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_back,
  input  logic [31:0] flush_target,
  input  logic        miss,
  input  logic [31:0] miss_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        full_ififo,
  output logic        icache_req,
  output logic [31:0] icache_addr,
  input  logic        icache_ready,
  input  logic        icache_valid,
  output logic [31:0] pc_fetch,
  output logic        pc_valid,
  output logic        flush_ifr,
  output logic        stall_ifr,
  output logic        stall_if_request
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    WAIT,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        kill_q, kill_d;

  logic        redir;
  logic [31:0] raw_tgt;
  logic [31:0] tgt;
  logic [31:0] seq_pc;

  always_comb begin
    raw_tgt = '0;
    priority case (1'b1)
      flush_back: raw_tgt = flush_target;
      miss:       raw_tgt = miss_target;
      jump:       raw_tgt = jump_target;
      default:    raw_tgt = '0;
    endcase
  end

  assign redir  = flush_back | miss | jump;
  assign tgt    = {raw_tgt[31:2], 2'b00};
  assign seq_pc = {pc_q[31:4] + 28'd1, 4'b0000};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    kill_d   = kill_q & ~flush_back;
    pc_valid = 1'b0;
    unique case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (redir) pc_d = tgt;
      end
      FETCH: begin
        if (redir) pc_d = tgt;
        if (icache_ready) begin
          state_d = WAIT;
          kill_d  = redir;
          pend_d  = redir ? tgt : pend_q;
        end
      end
      WAIT: begin
        if (icache_valid) begin
          state_d = FETCH;
          kill_d  = 1'b0;
          if (redir) begin
            pc_d = tgt;
          end else if (kill_q) begin
            pc_d = pend_q;
          end else if (!full_ififo) begin
            pc_valid = 1'b1;
            pc_d     = seq_pc;
          end else begin
            state_d = HOLD;
          end
        end else if (redir) begin
          // newest redirect wins while the response is in flight
          kill_d = 1'b1;
          pend_d = tgt;
        end
      end
      HOLD: begin
        if (redir) begin
          state_d = FETCH;
          pc_d    = tgt;
        end else if (!full_ififo) begin
          state_d  = FETCH;
          pc_valid = 1'b1;
          pc_d     = seq_pc;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      kill_q  <= kill_d;
    end
  end

  assign icache_req       = (state_q == FETCH);
  assign icache_addr      = pc_q;
  assign pc_fetch         = pc_q;
  assign flush_ifr        = redir;
  assign stall_ifr        = (state_q == HOLD) & full_ififo & ~redir;
  assign stall_if_request = ~pc_valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed cache handshakes with a
// queue of expected delivered block addresses.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        flush_back;
  logic [31:0] flush_target;
  logic        miss;
  logic [31:0] miss_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        full_ififo;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic        icache_valid;
  logic [31:0] pc_fetch;
  logic        pc_valid;
  logic        flush_ifr;
  logic        stall_ifr;
  logic        stall_if_request;

  int vecs;
  int errs;
  logic [31:0] exp_q[$];

  fetch_ctrl #(.RESET_PC(32'h1c00_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_back       (flush_back),
    .flush_target     (flush_target),
    .miss             (miss),
    .miss_target      (miss_target),
    .jump             (jump),
    .jump_target      (jump_target),
    .full_ififo       (full_ififo),
    .icache_req       (icache_req),
    .icache_addr      (icache_addr),
    .icache_ready     (icache_ready),
    .icache_valid     (icache_valid),
    .pc_fetch         (pc_fetch),
    .pc_valid         (pc_valid),
    .flush_ifr        (flush_ifr),
    .stall_ifr        (stall_ifr),
    .stall_if_request (stall_if_request)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Sample mid-cycle, score any delivery, then move to the next negedge.
  task automatic tick();
    logic [31:0] e;
    #2;
    if (pc_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_pc_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("deliver_pc", pc_fetch, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic clr_redir();
    flush_back = 1'b0;
    miss       = 1'b0;
    jump       = 1'b0;
  endtask

  // From FETCH at addr: accept, respond next cycle, expect delivery.
  task automatic block(input logic [31:0] addr);
    #1;
    chk("req_fetch", {31'd0, icache_req}, 32'd1);
    chk("req_addr", icache_addr, addr);
    icache_ready = 1'b1;
    tick();
    icache_ready = 1'b0;
    icache_valid = 1'b1;
    exp_q.push_back(addr);
    #1;
    chk("pcv_resp", {31'd0, pc_valid}, 32'd1);
    tick();
    icache_valid = 1'b0;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst = 1'b0;
    clr_redir();
    flush_target = '0;
    miss_target  = '0;
    jump_target  = '0;
    full_ififo   = 1'b0;
    icache_ready = 1'b0;
    icache_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", {31'd0, icache_req}, 32'd0);
    chk("rst_pc", pc_fetch, 32'h1c00_0000);
    chk("rst_pcv", {31'd0, pc_valid}, 32'd0);
    chk("rst_flush", {31'd0, flush_ifr}, 32'd0);
    chk("rst_stall", {31'd0, stall_ifr}, 32'd0);
    chk("rst_sreq", {31'd0, stall_if_request}, 32'd1);
    rst = 1'b1;
    #1;
    chk("boot_req", {31'd0, icache_req}, 32'd0);
    tick();

    // back-to-back sequential blocks
    block(32'h1c00_0000);
    block(32'h1c00_0010);
    block(32'h1c00_0020);

    // ready held low in FETCH
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("nr_req", {31'd0, icache_req}, 32'd1);
      chk("nr_addr", icache_addr, 32'h1c00_0030);
      chk("nr_sreq", {31'd0, stall_if_request}, 32'd1);
      chk("nr_pcv", {31'd0, pc_valid}, 32'd0);
      tick();
    end
    block(32'h1c00_0030);

    // response into a full FIFO -> HOLD
    icache_ready = 1'b1;
    tick();
    icache_ready = 1'b0;
    icache_valid = 1'b1;
    full_ififo   = 1'b1;
    #1;
    chk("full_pcv", {31'd0, pc_valid}, 32'd0);
    tick();
    icache_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("hold_stall", {31'd0, stall_ifr}, 32'd1);
      chk("hold_pcv", {31'd0, pc_valid}, 32'd0);
      tick();
    end
    full_ififo = 1'b0;
    exp_q.push_back(32'h1c00_0040);
    #1;
    chk("hold_rel_pcv", {31'd0, pc_valid}, 32'd1);
    chk("hold_rel_stall", {31'd0, stall_ifr}, 32'd0);
    tick();
    #1;
    chk("hold_next", icache_addr, 32'h1c00_0050);

    // jump + miss together in WAIT; miss wins, response discarded
    icache_ready = 1'b1;
    tick();
    icache_ready = 1'b0;
    jump = 1'b1;
    jump_target = 32'h1c00_0100;
    miss = 1'b1;
    miss_target = 32'h1c00_0200;
    #1;
    chk("wr_flush", {31'd0, flush_ifr}, 32'd1);
    chk("wr_pcv", {31'd0, pc_valid}, 32'd0);
    tick();
    clr_redir();
    tick();
    icache_valid = 1'b1;
    #1;
    chk("kill_pcv", {31'd0, pc_valid}, 32'd0);
    tick();
    icache_valid = 1'b0;
    block(32'h1c00_0200);

    // flush coincident with response into full FIFO
    icache_ready = 1'b1;
    tick();
    icache_ready = 1'b0;
    icache_valid = 1'b1;
    full_ififo   = 1'b1;
    flush_back   = 1'b1;
    flush_target = 32'h1c00_8000;
    #1;
    chk("fb_flush", {31'd0, flush_ifr}, 32'd1);
    chk("fb_pcv", {31'd0, pc_valid}, 32'd0);
    chk("fb_stall", {31'd0, stall_ifr}, 32'd0);
    tick();
    clr_redir();
    icache_valid = 1'b0;
    full_ififo   = 1'b0;
    #1;
    chk("fb_stall2", {31'd0, stall_ifr}, 32'd0);
    block(32'h1c00_8000);

    // redirect in FETCH while accepted: flush beats jump, killed
    icache_ready = 1'b1;
    flush_back   = 1'b1;
    flush_target = 32'h1c00_0302;
    jump         = 1'b1;
    jump_target  = 32'h1c00_0700;
    tick();
    clr_redir();
    icache_ready = 1'b0;
    icache_valid = 1'b1;
    #1;
    chk("fk_pcv", {31'd0, pc_valid}, 32'd0);
    tick();
    icache_valid = 1'b0;
    block(32'h1c00_0300);

    // wrap-around at the top of the address space
    jump = 1'b1;
    jump_target = 32'hffff_fff3;
    tick();
    clr_redir();
    block(32'hffff_fff0);
    #1;
    chk("wrap_addr", icache_addr, 32'h0000_0000);

    // reset while a request is outstanding
    icache_ready = 1'b1;
    tick();
    icache_ready = 1'b0;
    rst = 1'b0;
    #1;
    chk("mrst_pc", pc_fetch, 32'h1c00_0000);
    chk("mrst_req", {31'd0, icache_req}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    block(32'h1c00_0000);

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule
